key_handoff_ctrl: RTL
=====================

# key_handoff_ctrl

Synthesizable, parametrised key handoff controller between the RSA key generator and the transmitter/decrypter pair. It stages each generated public key (n, e) and raises `request` toward the transmitter. On accept it publishes the key and enables the decrypter. Beyond the basic handoff, it supports request timeout with bounded retries, a sticky error state, and live re-keying while the decrypter stays enabled on the previous key.

## Interface
- `KEY_WIDTH`, default 128: width of n and e.
- `TIMEOUT`, default 16: cycles `request` stays high per attempt before it is withdrawn; must be ≥1.
- `MAX_RETRY`, default 3: retries after the first attempt; total attempts = MAX_RETRY+1.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `key_valid`  in  1  one-cycle strobe: `n_wire`/`e_wire` hold a new key this cycle.
- `n_wire`  in  KEY_WIDTH  generated modulus.
- `e_wire`  in  KEY_WIDTH  generated public exponent.
- `accept`  in  1  transmitter acceptance, level; a 0→1 transition is the event.
- `n`  out  KEY_WIDTH  published modulus, registered.
- `e`  out  KEY_WIDTH  published exponent, registered.
- `request`  out  1  send request to transmitter, registered.
- `de_en`  out  1  decrypter enable, registered, sticky.
- `key_sent`  out  1  one-cycle pulse in the cycle n/e change.
- `error`  out  1  all attempts timed out, sticky.

## Operation
- Internal state: staging registers `stage_n`/`stage_e`, the registered `accept_q`, timer `tmr` of width $clog2(TIMEOUT+1), and attempt counter `att`.
- Accept edge: `acc_edge = accept & ~accept_q`.
- FSM states: IDLE, REQ, GAP, SEND, ACTIVE, ERR.
- IDLE:
  - outputs at reset values except n/e.
  - `key_valid` → capture the key into stage, tmr=0, att=0, go to REQ.
- REQ:
  - `request`=1; tmr increments each cycle.
  - `acc_edge` → SEND.
  - Otherwise, when tmr reaches TIMEOUT-1: if att==MAX_RETRY go to ERR, else att+1 and go to GAP.
- GAP: `request`=0 for exactly one cycle; tmr=0; return to REQ.
- SEND:
  - One cycle.
  - `request`=0.
  - At the closing edge: n←stage_n, e←stage_e, de_en←1, and `key_sent` is high in the following cycle.
  - Then go to ACTIVE.
- ACTIVE:
  - de_en=1, request=0.
  - `key_valid` → stage the new key, tmr=0, att=0, go to REQ.
  - During this re-key, n/e/de_en keep the old key until the next SEND.
- ERR:
  - error=1, request=0; de_en keeps its prior value.
  - `key_valid` → clear error, stage the key, tmr=0, att=0, go to REQ.
- `key_valid` in REQ or GAP: restage the new key, tmr=0, att=0, go to REQ (this restarts the attempt sequence).
- `key_valid` and `acc_edge` in the same REQ cycle: the stage takes the new key and the FSM goes to SEND, so the newest key is delivered.
- `key_valid` during SEND: ignored, because the staged key is already committed.
- `accept` held high across attempts produces no new edge and does not complete the handoff.

## Timing
- Reset values: n=0, e=0, request=0, de_en=0, key_sent=0, error=0. Internal state: FSM=IDLE, stage=0, tmr=0, att=0, accept_q=0.
- Reset asserted mid-operation clears everything on the next edge, including de_en.
- `key_valid` sampled at edge T → `request`=1 from T+1.
- Accept edge sampled at edge A → `request`=0 from A+1 (SEND); n/e/de_en/key_sent updated at A+2.
- Handoff latency is 2 cycles from the sampled accept rise to published key.
- Request high for exactly TIMEOUT cycles per attempt, then 1 low cycle (GAP), then high again.
- Error asserts TIMEOUT cycles after the start of the last attempt; there is no GAP before ERR.
- `key_sent` width is exactly 1 cycle; n/e never change outside that cycle.

## Test plan
Tests use KEY_WIDTH=16, TIMEOUT=4, MAX_RETRY=1.
- Basic handoff:
  - Stimulus: reset, `key_valid` with n=0x00C5, e=0x0011, then accept rises 2 cycles later.
  - Expect request high 2 cycles then low; n=0x00C5, e=0x0011, de_en=1, and a single key_sent pulse 2 cycles after the accept is sampled.
- Retry then success:
  - Stimulus: no accept for 4 cycles, then accept rises during the second attempt.
  - Expect request pattern 1111 0 1…, error=0, key delivered.
- Exhaustion:
  - Stimulus: accept never rises.
  - Expect request 1111 0 1111 then 0; error=1 from cycle 10 after key_valid; n=e=0, de_en=0.
- Re-key in ACTIVE:
  - Stimulus: deliver 0x00C5/0x0011, then `key_valid` with 0x00BB/0x0003.
  - Expect request re-raised and n stays 0x00C5 with de_en=1 until the next accept edge, after which n=0x00BB.
- Simultaneous event:
  - Stimulus: `key_valid` (0x0077) in the same cycle as the accept edge while in REQ.
  - Expect the published n=0x0077.
- Reset mid-REQ and from ERR:
  - Stimulus: rst_n low for 1 cycle.
  - Expect all outputs at zero the next cycle; in ERR, a new `key_valid` instead clears error and request rises the next cycle.

Source files
------------

// File: rtl/key_handoff_ctrl.sv
// key_handoff_ctrl: stages generated RSA public keys, requests the transmitter with
// timeout/retry, then publishes the key and enables the decrypter.
module key_handoff_ctrl #(
    parameter int KEY_WIDTH = 128,
    parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 key_valid,
    input  logic [KEY_WIDTH-1:0] n_wire,
    input  logic [KEY_WIDTH-1:0] e_wire,
    input  logic                 accept,
    output logic [KEY_WIDTH-1:0] n,
    output logic [KEY_WIDTH-1:0] e,
    output logic                 request,
    output logic                 de_en,
    output logic                 key_sent,
    output logic                 error
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int AW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {IDLE, REQ, GAP, SEND, ACTIVE, ERR} state_t;

    state_t               state, state_d;
    logic [KEY_WIDTH-1:0] stage_n, stage_e;
    logic [TW-1:0]        tmr, tmr_d;
    logic [AW-1:0]        att, att_d;
    logic                 accept_q, acc_edge, load;

    assign acc_edge = accept & ~accept_q;

    always_comb begin
        state_d = state;
        tmr_d   = tmr;
        att_d   = att;
        load    = 1'b0;
        case (state)
            IDLE, ACTIVE, ERR: begin
                if (key_valid) begin
                    load    = 1'b1;
                    tmr_d   = '0;
                    att_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // an accept edge wins over a new key; the new key is still staged so it is the one delivered
                if (key_valid) begin
                    load    = 1'b1;
                    tmr_d   = '0;
                    att_d   = '0;
                    state_d = acc_edge ? SEND : REQ;
                end else if (acc_edge) begin
                    state_d = SEND;
                end else if (tmr == TW'(TIMEOUT - 1)) begin
                    tmr_d   = '0;
                    state_d = (att == AW'(MAX_RETRY)) ? ERR : GAP;
                    att_d   = (att == AW'(MAX_RETRY)) ? att : att + 1'b1;
                end else begin
                    tmr_d = tmr + 1'b1;
                end
            end
            GAP: begin
                tmr_d   = '0;
                load    = key_valid;
                att_d   = key_valid ? '0 : att;
                state_d = REQ;
            end
            SEND:    state_d = ACTIVE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            stage_n  <= '0;
            stage_e  <= '0;
            tmr      <= '0;
            att      <= '0;
            accept_q <= 1'b0;
            n        <= '0;
            e        <= '0;
            request  <= 1'b0;
            de_en    <= 1'b0;
            key_sent <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= state_d;
            tmr      <= tmr_d;
            att      <= att_d;
            accept_q <= accept;
            if (load) begin
                stage_n <= n_wire;
                stage_e <= e_wire;
            end
            if (state == SEND) begin
                n     <= stage_n;
                e     <= stage_e;
                de_en <= 1'b1;
            end
            key_sent <= (state == SEND);
            request  <= (state_d == REQ);
            error    <= (state_d == ERR);
        end
    end
endmodule
